// File: rtl/ultrasonic_pkg.sv
// Shared types and default constants for the ultrasonic echo ranger.
// Provides the FSM state enum and the timing/width defaults.
package ultrasonic_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_ECHO,
      MEASURE,
      DONE
   } ranger_state_t;

   localparam int TICKS_PER_US = 50;
   localparam int US_PER_CM    = 58;
   localparam int TIMEOUT_US   = 38000;
   localparam int US_CNT_W     = 16;

endpackage

// File: rtl/bcd2_sat_counter.sv
// Two-digit BCD up-counter that holds at 99 and flags the overflow.
// Ports: clk, rst, clear, inc in; tens, ones (BCD), sat out.
module bcd2_sat_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       inc,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       sat
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         tens <= 4'd0;
         ones <= 4'd0;
         sat  <= 1'b0;
      end else if (inc) begin
         if (tens == 4'd9 && ones == 4'd9) begin
            sat <= 1'b1;
         end else if (ones == 4'd9) begin
            ones <= 4'd0;
            tens <= tens + 4'd1;
         end else begin
            ones <= ones + 4'd1;
         end
      end
   end

endmodule

// File: rtl/ultrasonic_echo_ranger.sv
// Measures echo pulse width, converts it to whole cm as two BCD digits.
// Ports: clk, rst, on_off, start, echo in; dist_tens/ones, dist_valid, no_object, over_range, busy out.
module ultrasonic_echo_ranger #(
   parameter int TICKS_PER_US = ultrasonic_pkg::TICKS_PER_US,
   parameter int US_PER_CM    = ultrasonic_pkg::US_PER_CM,
   parameter int TIMEOUT_US   = ultrasonic_pkg::TIMEOUT_US
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       on_off,
   input  logic       start,
   input  logic       echo,
   output logic [3:0] dist_ones,
   output logic [3:0] dist_tens,
   output logic       dist_valid,
   output logic       no_object,
   output logic       over_range,
   output logic       busy
);

   import ultrasonic_pkg::*;

   localparam int TICK_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
   localparam int CM_W   = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;

   localparam logic [TICK_W-1:0]   TICK_LAST  = TICK_W'(TICKS_PER_US - 1);
   localparam logic [CM_W-1:0]     CM_LAST    = CM_W'(US_PER_CM - 1);
   localparam logic [US_CNT_W-1:0] US_TIMEOUT = US_CNT_W'(TIMEOUT_US);
   localparam logic [US_CNT_W-1:0] US_LAST    = US_CNT_W'(TIMEOUT_US - 1);

   logic echo_m, echo_s, echo_d;
   logic echo_rise, echo_fall;

   ranger_state_t state, state_nx;
   logic clr_all, clr_meas;
   logic running, us_tick, timeout, cm_wrap;
   logic to_flag;

   logic [TICK_W-1:0]   tick;
   logic [US_CNT_W-1:0] us_cnt;
   logic [CM_W-1:0]     cm_cnt;

   logic [3:0] bcd_tens, bcd_ones;
   logic       over_range_pend;

   always_ff @(posedge clk) begin
      if (rst) begin
         echo_m <= 1'b0;
         echo_s <= 1'b0;
         echo_d <= 1'b0;
      end else begin
         echo_m <= echo;
         echo_s <= echo_m;
         echo_d <= echo_s;
      end
   end

   assign echo_rise = echo_s & ~echo_d;
   assign echo_fall = ~echo_s & echo_d;

   assign running = (state == WAIT_ECHO) || (state == MEASURE);
   assign us_tick = running && (tick == TICK_LAST);
   // Fires on the tick that carries the count to TIMEOUT_US, so the
   // counter holds TIMEOUT_US during DONE.
   assign timeout = us_tick && (us_cnt == US_LAST);
   assign cm_wrap = us_tick && (state == MEASURE) && (cm_cnt == CM_LAST);

   always_comb begin
      state_nx = state;
      clr_all  = 1'b0;
      clr_meas = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && on_off) begin
               state_nx = WAIT_ECHO;
               clr_all  = 1'b1;
            end
         end
         WAIT_ECHO: begin
            if (timeout) begin
               state_nx = DONE;
            end else if (echo_rise) begin
               state_nx = MEASURE;
               clr_meas = 1'b1;
            end
         end
         MEASURE: begin
            if (timeout || echo_fall) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
      if (!on_off) begin
         state_nx = IDLE;
         clr_all  = 1'b0;
         clr_meas = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Tick phase restarts at the echo rise so truncation is exact.
   always_ff @(posedge clk) begin
      if (rst || clr_all || clr_meas) begin
         tick   <= '0;
         us_cnt <= '0;
         cm_cnt <= '0;
      end else if (running) begin
         tick <= us_tick ? '0 : tick + 1'b1;
         if (us_tick) begin
            if (us_cnt != US_TIMEOUT) begin
               us_cnt <= us_cnt + 1'b1;
            end
            cm_cnt <= (cm_cnt == CM_LAST) ? '0 : cm_cnt + 1'b1;
         end
      end
   end

   // Captured on the last running cycle, i.e. the one that enters DONE.
   always_ff @(posedge clk) begin
      if (rst || clr_all) begin
         to_flag <= 1'b0;
      end else if (running) begin
         to_flag <= timeout;
      end
   end

   bcd2_sat_counter u_bcd (
      .clk   (clk),
      .rst   (rst),
      .clear (clr_all),
      .inc   (cm_wrap),
      .tens  (bcd_tens),
      .ones  (bcd_ones),
      .sat   (over_range_pend)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         dist_ones  <= 4'd0;
         dist_tens  <= 4'd0;
         dist_valid <= 1'b0;
         no_object  <= 1'b0;
         over_range <= 1'b0;
      end else begin
         dist_valid <= 1'b0;
         if (state == DONE && on_off) begin
            dist_valid <= 1'b1;
            no_object  <= to_flag;
            over_range <= !to_flag && over_range_pend;
            if (!to_flag) begin
               dist_tens <= bcd_tens;
               dist_ones <= bcd_ones;
            end
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_ultrasonic_echo_ranger.sv
// Self-checking bench for ultrasonic_echo_ranger with scaled timing.
// Random echo widths are scored against an arithmetic distance model.
module tb_ultrasonic_echo_ranger;

   localparam int TPU    = 2;
   localparam int UPC    = 5;
   localparam int TOU    = 600;
   localparam int TO_CYC = TOU * TPU;

   logic       clk = 1'b0;
   logic       rst, on_off, start, echo;
   logic [3:0] dist_ones, dist_tens;
   logic       dist_valid, no_object, over_range, busy;

   int cyc = 0;
   int dv_cnt = 0;
   int checks = 0;
   int errors = 0;

   int m_tens = 0, m_ones = 0, m_noobj = 0, m_over = 0;

   ultrasonic_echo_ranger #(
      .TICKS_PER_US (TPU),
      .US_PER_CM    (UPC),
      .TIMEOUT_US   (TOU)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .on_off     (on_off),
      .start      (start),
      .echo       (echo),
      .dist_ones  (dist_ones),
      .dist_tens  (dist_tens),
      .dist_valid (dist_valid),
      .no_object  (no_object),
      .over_range (over_range),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (dist_valid === 1'b1) dv_cnt <= dv_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Distance rule: whole us elapsed, then whole cm, clamped at 99.
   task automatic model(input int w);
      int us, cm;
      us = w / TPU;
      if (us >= TOU) begin
         m_noobj = 1;
         m_over  = 0;
      end else begin
         cm      = us / UPC;
         m_over  = (cm > 99) ? 1 : 0;
         if (cm > 99) cm = 99;
         m_tens  = cm / 10;
         m_ones  = cm % 10;
         m_noobj = 0;
      end
   endtask

   task automatic chk_outs(input string tag);
      chk({tag, "_tens"}, dist_tens, m_tens);
      chk({tag, "_ones"}, dist_ones, m_ones);
      chk({tag, "_noobj"}, no_object, m_noobj);
      chk({tag, "_over"}, over_range, m_over);
   endtask

   task automatic wait_dv(input int budget, output int got);
      bit seen;
      seen = 0;
      got  = -1;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (dist_valid === 1'b1) begin
            seen = 1;
            got  = cyc;
         end
      end
   endtask

   task automatic do_start(output int s);
      @(posedge clk); #1 start = 1'b1;
      s = cyc + 1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("busy_after_start", busy, 1);
   endtask

   task automatic measure(input int w, input bit mid);
      int n0, s, gap, h, kc, got;
      n0  = dv_cnt;
      do_start(s);
      gap = $urandom_range(1, 6);
      repeat (gap) @(posedge clk);
      #1 echo = 1'b1;
      if (mid) begin
         h = w / 2;
         repeat (h) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
         repeat (w - h - 1) @(posedge clk);
      end else begin
         repeat (w) @(posedge clk);
      end
      #1 echo = 1'b0;
      kc = cyc + 1;
      model(w);
      wait_dv(12, got);
      chk($sformatf("latency_w%0d", w), got, kc + 3);
      chk_outs($sformatf("w%0d", w));
      @(negedge clk);
      chk("dv_one_cycle", dist_valid, 0);
      chk("busy_idle", busy, 0);
      repeat (3) @(posedge clk);
      chk("dv_count", dv_cnt - n0, 1);
   endtask

   initial begin
      int s, got, n0, w;
      rst = 1'b1; on_off = 1'b1; start = 1'b0; echo = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ones", dist_ones, 0);
      chk("rst_tens", dist_tens, 0);
      chk("rst_dv", dist_valid, 0);
      chk("rst_noobj", no_object, 0);
      chk("rst_over", over_range, 0);
      chk("rst_busy", busy, 0);

      measure(100, 0);
      measure(170, 0);
      measure(9, 0);
      measure(1100, 0);
      measure(100, 0);
      measure(990, 0);
      measure(1000, 0);
      measure(1199, 0);
      measure(1200, 0);
      measure(1, 0);

      n0 = dv_cnt;
      do_start(s);
      wait_dv(TO_CYC + 10, got);
      m_noobj = 1;
      m_over  = 0;
      chk("timeout_latency", got, s + TO_CYC + 1);
      chk_outs("timeout");
      repeat (3) @(posedge clk);
      chk("timeout_dv_count", dv_cnt - n0, 1);

      for (int i = 0; i < 8; i++) begin
         w = $urandom_range(10, TO_CYC - 1);
         measure(w, i[0]);
      end

      n0 = dv_cnt;
      do_start(s);
      repeat (3) @(posedge clk);
      #1 echo = 1'b1;
      repeat (300) @(posedge clk);
      #1 on_off = 1'b0;
      @(posedge clk); #1 on_off = 1'b1;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      repeat (200) @(posedge clk);
      #1 echo = 1'b0;
      repeat (12) @(posedge clk);
      chk("abort_no_dv", dv_cnt - n0, 0);
      @(negedge clk);
      chk_outs("abort_hold");

      @(posedge clk); #1 start = 1'b1; on_off = 1'b0;
      @(posedge clk); #1 start = 1'b0; on_off = 1'b1;
      @(negedge clk);
      chk("start_off_busy", busy, 0);

      n0 = dv_cnt;
      @(posedge clk); #1 echo = 1'b1;
      repeat (50) @(posedge clk);
      #1 echo = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("idle_echo_busy", busy, 0);
      chk("idle_echo_no_dv", dv_cnt - n0, 0);

      measure(250, 0);

      n0 = dv_cnt;
      do_start(s);
      repeat (2) @(posedge clk);
      #1 echo = 1'b1;
      repeat (300) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      m_tens = 0; m_ones = 0; m_noobj = 0; m_over = 0;
      @(negedge clk);
      chk_outs("midrst");
      chk("midrst_dv", dist_valid, 0);
      chk("midrst_busy", busy, 0);
      repeat (300) @(posedge clk);
      #1 echo = 1'b0;
      repeat (12) @(posedge clk);
      chk("midrst_no_dv", dv_cnt - n0, 0);

      measure(580, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
